// File: rtl/axil_avalon_rw_scheduler.sv
// AXI4-Lite to Avalon-MM bridge: serialises reads and writes onto one Avalon master
// port with round-robin arbitration, address-window decode and a waitrequest timeout.
module axil_avalon_rw_scheduler #(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_FFFF,
  parameter int unsigned C_TIMEOUT  = 256
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [31:0] oAvsPcpAddress,
  output logic [3:0]  oAvsPcpByteenable,
  output logic        oAvsPcpRead,
  output logic        oAvsPcpWrite,
  output logic [31:0] oAvsPcpWritedata,
  input  logic [31:0] iAvsPcpReaddata,
  input  logic        iAvsPcpWaitrequest
);
  localparam int unsigned CNT_W = $clog2(C_TIMEOUT);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, WR_ACC, RD_ACC, WR_RESP, RD_RESP} state_t;

  state_t           state_q, state_d;
  logic             last_wr_q, last_wr_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [3:0]       be_q, be_d;
  logic [1:0]       resp_q, resp_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             wr_pend, rd_pend, grant_wr, grant_rd;
  logic             aw_in_win, ar_in_win;

  // Offset-from-base compare covers both window bounds with one unsigned test.
  assign aw_in_win = (S_AXI_AWADDR - C_BASEADDR) <= (C_HIGHADDR - C_BASEADDR);
  assign ar_in_win = (S_AXI_ARADDR - C_BASEADDR) <= (C_HIGHADDR - C_BASEADDR);

  assign wr_pend  = S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_pend  = S_AXI_ARVALID;
  assign grant_wr = ARESETN & (state_q == IDLE) & wr_pend & (~rd_pend | ~last_wr_q);
  assign grant_rd = ARESETN & (state_q == IDLE) & rd_pend & (~wr_pend | last_wr_q);

  assign S_AXI_AWREADY     = grant_wr;
  assign S_AXI_WREADY      = grant_wr;
  assign S_AXI_ARREADY     = grant_rd;
  assign S_AXI_BVALID      = (state_q == WR_RESP);
  assign S_AXI_RVALID      = (state_q == RD_RESP);
  assign S_AXI_BRESP       = resp_q;
  assign S_AXI_RRESP       = resp_q;
  assign S_AXI_RDATA       = rdata_q;
  assign oAvsPcpAddress    = addr_q;
  assign oAvsPcpByteenable = be_q;
  assign oAvsPcpWritedata  = wdata_q;
  assign oAvsPcpWrite      = (state_q == WR_ACC);
  assign oAvsPcpRead       = (state_q == RD_ACC);

  always_comb begin
    state_d    = state_q;
    last_wr_d  = last_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    be_d       = be_q;
    resp_d     = resp_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          addr_d     = {S_AXI_AWADDR[31:2], 2'b00};
          wdata_d    = S_AXI_WDATA;
          be_d       = S_AXI_WSTRB;
          last_wr_d  = 1'b1;
          wait_cnt_d = '0;
          resp_d     = RESP_OKAY;
          if (!aw_in_win) begin
            resp_d  = RESP_DECERR;
            state_d = WR_RESP;
          end else if (S_AXI_WSTRB == 4'h0) begin
            state_d = WR_RESP;
          end else begin
            state_d = WR_ACC;
          end
        end else if (grant_rd) begin
          addr_d     = {S_AXI_ARADDR[31:2], 2'b00};
          be_d       = '1;
          last_wr_d  = 1'b0;
          wait_cnt_d = '0;
          rdata_d    = '0;
          resp_d     = RESP_OKAY;
          if (!ar_in_win) begin
            resp_d  = RESP_DECERR;
            state_d = RD_RESP;
          end else begin
            state_d = RD_ACC;
          end
        end
      end
      WR_ACC, RD_ACC: begin
        if (!iAvsPcpWaitrequest) begin
          resp_d  = RESP_OKAY;
          if (state_q == RD_ACC) rdata_d = iAvsPcpReaddata;
          state_d = (state_q == RD_ACC) ? RD_RESP : WR_RESP;
        end else if (wait_cnt_q == CNT_W'(C_TIMEOUT - 1)) begin
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
          state_d = (state_q == RD_ACC) ? RD_RESP : WR_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      WR_RESP: if (S_AXI_BREADY) state_d = IDLE;
      RD_RESP: if (S_AXI_RREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      last_wr_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      be_q       <= '0;
      resp_q     <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_wr_q  <= last_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      be_q       <= be_d;
      resp_q     <= resp_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
endmodule

// File: tb/tb_axil_avalon_rw_scheduler.sv
// Randomised bench for axil_avalon_rw_scheduler: AXI-level reference model plus an
// Avalon slave that checks each access against what the model says must happen.
module tb_axil_avalon_rw_scheduler;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] HIGH = 32'h0000_FFFF;
  localparam int unsigned TO   = 8;

  logic        ACLK = 1'b0, ARESETN = 1'b0;
  logic [31:0] S_AXI_AWADDR = '0, S_AXI_WDATA = '0, S_AXI_ARADDR = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0;
  logic        S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
  logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0] S_AXI_RDATA, oAvsPcpAddress, oAvsPcpWritedata;
  logic [3:0]  oAvsPcpByteenable;
  logic        oAvsPcpRead, oAvsPcpWrite;
  logic [31:0] iAvsPcpReaddata = '0;
  logic        iAvsPcpWaitrequest = 1'b0;

  axil_avalon_rw_scheduler #(.C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .oAvsPcpAddress(oAvsPcpAddress), .oAvsPcpByteenable(oAvsPcpByteenable),
    .oAvsPcpRead(oAvsPcpRead), .oAvsPcpWrite(oAvsPcpWrite), .oAvsPcpWritedata(oAvsPcpWritedata),
    .iAvsPcpReaddata(iAvsPcpReaddata), .iAvsPcpWaitrequest(iAvsPcpWaitrequest)
  );

  always #5 ACLK = ~ACLK;
  int unsigned cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  logic [110:0] outs;
  assign outs = {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
                 S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, oAvsPcpAddress, oAvsPcpByteenable,
                 oAvsPcpRead, oAvsPcpWrite, oAvsPcpWritedata};

  int unsigned n_checks = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int unsigned stall;
    int unsigned cycles;
  } acc_t;

  // Reference model state: expected memory contents, arbitration history, expected accesses.
  acc_t        exp_q[$];
  logic [31:0] model_mem[16];
  logic [31:0] slave_mem[16];
  bit          model_last_wr = 0;
  int          grant_log[$];
  bit          abort_acc = 0;

  function automatic bit in_window(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) <= longint'(HIGH));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int unsigned stall);
    bit ok; bit stable; int unsigned h, n, waits; logic [1:0] er; acc_t e;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (S_AXI_AWREADY && S_AXI_WREADY) begin ok = 1; break; end
      @(posedge ACLK);
    end
    check_eq("aw_handshake", ok, 1);
    if (ok) @(posedge ACLK);
    #1;
    h = cyc;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    S_AXI_AWADDR = $urandom; S_AXI_WDATA = $urandom; S_AXI_WSTRB = 4'($urandom);
    if (!ok) return;
    grant_log.push_back(1);
    model_last_wr = 1;
    n = 0; er = 2'b00;
    if (!in_window(a)) er = 2'b11;
    else if (s != 4'h0) begin
      n = (stall >= TO) ? TO : stall + 1;
      if (stall >= TO) er = 2'b10;
      else model_mem[a[5:2]] = merge(model_mem[a[5:2]], d, s);
      e = '{wr: 1'b1, addr: {a[31:2], 2'b00}, be: s, wdata: d, stall: stall, cycles: n};
      exp_q.push_back(e);
    end
    S_AXI_BREADY = ($urandom_range(0, 1) == 1);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) begin ok = 1; break; end
    end
    check_eq("b_valid_seen", ok, 1);
    if (ok) begin
      check_eq("b_latency", cyc - h, n);
      check_eq("b_resp", S_AXI_BRESP, er);
      if (!S_AXI_BREADY) begin
        waits = $urandom_range(0, 2); stable = 1;
        repeat (waits) begin
          @(negedge ACLK);
          if (!S_AXI_BVALID || S_AXI_BRESP !== er) stable = 0;
        end
        check_eq("b_hold", stable, 1);
        S_AXI_BREADY = 1;
      end
      @(posedge ACLK); #1;
      check_eq("b_release", S_AXI_BVALID, 0);
    end
    S_AXI_BREADY = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input int unsigned stall);
    bit ok; bit stable; int unsigned h, n, waits; logic [1:0] er; logic [31:0] ed; acc_t e;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (S_AXI_ARREADY) begin ok = 1; break; end
      @(posedge ACLK);
    end
    check_eq("ar_handshake", ok, 1);
    if (ok) @(posedge ACLK);
    #1;
    h = cyc;
    S_AXI_ARVALID = 0; S_AXI_ARADDR = $urandom;
    if (!ok) return;
    grant_log.push_back(0);
    model_last_wr = 0;
    n = 0; er = 2'b00; ed = '0;
    if (!in_window(a)) er = 2'b11;
    else begin
      n = (stall >= TO) ? TO : stall + 1;
      if (stall >= TO) er = 2'b10;
      else ed = model_mem[a[5:2]];
      e = '{wr: 1'b0, addr: {a[31:2], 2'b00}, be: 4'hF, wdata: '0, stall: stall, cycles: n};
      exp_q.push_back(e);
    end
    S_AXI_RREADY = ($urandom_range(0, 1) == 1);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (S_AXI_RVALID) begin ok = 1; break; end
    end
    check_eq("r_valid_seen", ok, 1);
    if (ok) begin
      check_eq("r_latency", cyc - h, n);
      check_eq("r_resp", S_AXI_RRESP, er);
      check_eq("r_data", S_AXI_RDATA, ed);
      if (!S_AXI_RREADY) begin
        waits = $urandom_range(0, 2); stable = 1;
        repeat (waits) begin
          @(negedge ACLK);
          if (!S_AXI_RVALID || S_AXI_RRESP !== er || S_AXI_RDATA !== ed) stable = 0;
        end
        check_eq("r_hold", stable, 1);
        S_AXI_RREADY = 1;
      end
      @(posedge ACLK); #1;
      check_eq("r_release", S_AXI_RVALID, 0);
    end
    S_AXI_RREADY = 0;
  endtask

  // Both channels offered in the same cycle from idle: round-robin picks the type not granted last.
  task automatic run_pair(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                          input int unsigned wst, input logic [31:0] ra, input int unsigned rst);
    int first; int base;
    first = model_last_wr ? 0 : 1;
    base  = grant_log.size();
    fork
      do_write(wa, wd, ws, wst);
      do_read(ra, rst);
    join
    if (grant_log.size() > base) check_eq("pair_first_grant", grant_log[base], first);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    if (r <= 6) return 32'($urandom_range(0, 63));
    if (r == 7) return 32'h0000_FFFC + 32'($urandom_range(0, 3));
    if (r == 8) return 32'h0001_0000 + 32'($urandom_range(0, 3));
    return $urandom | 32'h0001_0000;
  endfunction

  function automatic int unsigned rand_stall();
    int unsigned r = $urandom_range(0, 9);
    if (r <= 5) return $urandom_range(0, 3);
    if (r == 6) return TO - 1;
    if (r == 7) return $urandom_range(TO, TO + 2);
    return 0;
  endfunction

  initial begin : avalon_slave
    acc_t cur; bit in_acc; bit unstable; int unsigned k;
    in_acc = 0; unstable = 0; k = 0;
    forever begin
      @(negedge ACLK);
      if (oAvsPcpRead || oAvsPcpWrite) begin
        check_eq("rw_exclusive", oAvsPcpRead & oAvsPcpWrite, 0);
        if (!in_acc) begin
          in_acc = 1; k = 0; unstable = 0;
          if (exp_q.size() == 0) begin
            check_eq("unexpected_access", 1, 0);
            cur = '{wr: oAvsPcpWrite, addr: oAvsPcpAddress, be: oAvsPcpByteenable,
                    wdata: oAvsPcpWritedata, stall: 0, cycles: 1};
          end else begin
            cur = exp_q.pop_front();
            check_eq("acc_dir", oAvsPcpWrite, cur.wr);
            check_eq("acc_addr", oAvsPcpAddress, cur.addr);
            check_eq("acc_be", oAvsPcpByteenable, cur.be);
            if (cur.wr) check_eq("acc_wdata", oAvsPcpWritedata, cur.wdata);
          end
        end else if (oAvsPcpWrite !== cur.wr || oAvsPcpAddress !== cur.addr ||
                     oAvsPcpByteenable !== cur.be || (cur.wr && oAvsPcpWritedata !== cur.wdata))
          unstable = 1;
        iAvsPcpWaitrequest = (k < cur.stall);
        if (k >= cur.stall) begin
          if (cur.wr) slave_mem[cur.addr[5:2]] = merge(slave_mem[cur.addr[5:2]], cur.wdata, cur.be);
          iAvsPcpReaddata = slave_mem[cur.addr[5:2]];
        end else iAvsPcpReaddata = $urandom;
        k++;
      end else begin
        if (in_acc) begin
          if (!abort_acc) check_eq("acc_cycles", k, cur.cycles);
          check_eq("acc_stable", unstable, 0);
          in_acc = 0; abort_acc = 0;
        end
        iAvsPcpWaitrequest = ($urandom_range(0, 1) == 1);
        iAvsPcpReaddata = $urandom;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : main
    int base; bit ok; logic [31:0] v;
    for (int i = 0; i < 16; i++) begin v = $urandom; model_mem[i] = v; slave_mem[i] = v; end
    model_mem[8] = 32'h1234_5678; slave_mem[8] = 32'h1234_5678;

    repeat (3) @(negedge ACLK);
    check_eq("reset_outputs", outs, '0);
    ARESETN = 1;
    @(negedge ACLK);
    check_eq("post_reset_outputs", outs, '0);

    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    do_read(32'h20, 3);
    do_read(32'h0001_0000, 0);
    do_read(32'h0000_FFFF, 1);
    do_write(32'h14, 32'hCAFE_F00D, 4'h0, 0);
    do_write(32'h0001_0000, 32'h1111_2222, 4'hF, 0);
    do_write(32'h18, 32'hA5A5_5A5A, 4'hF, TO + 4);
    do_read(32'h18, 0);
    do_write(32'h1C, 32'h0BAD_CAFE, 4'h5, TO - 1);
    do_read(32'h1C, 0);

    // Reset during a stalled read: request drops, transaction discarded, outputs clear.
    S_AXI_ARADDR = 32'h30; S_AXI_ARVALID = 1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (S_AXI_ARREADY) begin ok = 1; break; end
      @(posedge ACLK);
    end
    check_eq("rst_ar_handshake", ok, 1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 0;
    exp_q.push_back('{wr: 1'b0, addr: 32'h30, be: 4'hF, wdata: '0, stall: 40, cycles: TO});
    abort_acc = 1;
    repeat (2) @(negedge ACLK);
    check_eq("rd_active_before_reset", oAvsPcpRead, 1);
    ARESETN = 0;
    @(negedge ACLK);
    check_eq("reset_mid_access_outputs", outs, '0);
    ARESETN = 1;
    model_last_wr = 0;
    @(negedge ACLK);

    // Write re-offered right after its response while a read waits: grants W, R, W.
    base = grant_log.size();
    fork
      begin
        do_write(32'h24, 32'h0102_0304, 4'hF, 0);
        do_write(32'h28, 32'h0506_0708, 4'hF, 1);
      end
      do_read(32'h24, 2);
    join
    check_eq("grant_seq_len", grant_log.size() - base, 3);
    if (grant_log.size() - base == 3) begin
      check_eq("grant_seq_0", grant_log[base], 1);
      check_eq("grant_seq_1", grant_log[base + 1], 0);
      check_eq("grant_seq_2", grant_log[base + 2], 1);
    end

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 4))
        0, 1: do_write(rand_addr(), $urandom,
                       ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), rand_stall());
        2, 3: do_read(rand_addr(), rand_stall());
        default: run_pair(rand_addr(), $urandom, 4'($urandom_range(0, 15)), rand_stall(),
                          rand_addr(), rand_stall());
      endcase
    end

    repeat (3) @(negedge ACLK);
    check_eq("acc_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
